turn_ctrl: RTL and testbench

Game-level turn arbiter that drives `whose_turn` into the local throw FSM and tracks the opponent's throws over the inter-board pin link. It alternates turns between the local and the remote board:
- local throw completion is detected from the local `throw_enable` level;
- remote throws are detected from the filtered `space_pin_rx` pin, fed by the other board's `space_pin_tx`.

While the remote projectile is in flight it drives a remote-flight enable for the local renderer.

---
 rtl/cvd_pkg.sv | 22 ++
 rtl/pin_sync_filter.sv | 46 ++++
 rtl/turn_ctrl.sv | 106 ++++++++++
 tb/tb_turn_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cvd_pkg.sv
// Shared game-level types and constants for the turn arbiter and related blocks.
package cvd_pkg;

  localparam int unsigned ONE_SECOND = 65_000_000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_L_WAIT,
    ST_L_FLIGHT,
    ST_GAP_TO_R,
    ST_R_WAIT,
    ST_R_PRESS,
    ST_R_FLIGHT,
    ST_GAP_TO_L,
    ST_OVER
  } turn_state_t;

  function automatic logic turn_is_local(input turn_state_t s);
    return (s == ST_L_WAIT) || (s == ST_L_FLIGHT);
  endfunction

endpackage

// File: rtl/pin_sync_filter.sv
// Two-flop synchronizer plus stability filter for a slow asynchronous inter-board pin.
module pin_sync_filter #(
  parameter int unsigned STABLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = $clog2(STABLE + 1);

  logic          sync1_q, sync2_q;
  logic          dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only advances while the synchronized pin disagrees with the output.
  always_comb begin
    dout_d = dout_q;
    cnt_d  = '0;
    if (sync2_q != dout_q) begin
      if (cnt_q == CW'(STABLE - 1)) begin
        dout_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/turn_ctrl.sv
// Alternates local/remote turns, times the remote flight and inter-turn gaps, counts turns.
module turn_ctrl
  import cvd_pkg::*;
#(
  parameter int unsigned FLIGHT_CYCLES = ONE_SECOND,
  parameter int unsigned GAP_CYCLES    = 1024,
  parameter int unsigned SYNC_STABLE   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_start,
  input  logic       game_over,
  input  logic       start_first,
  input  logic       throw_enable,
  input  logic       space_pin_rx,
  output logic       whose_turn,
  output logic       remote_throw_enable,
  output logic       remote_space,
  output logic [7:0] turn_num
);

  localparam logic [31:0] FLIGHT_LAST = 32'(FLIGHT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST    = 32'(GAP_CYCLES - 1);

  turn_state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  turn_q, turn_d;
  logic        te_q, rs_q;
  logic        whose_q, rte_q;
  logic        space_w;
  logic        te_rise, te_fall, rs_rise, rs_fall;
  logic        timed;

  pin_sync_filter #(.STABLE(SYNC_STABLE)) u_space_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (space_pin_rx),
    .dout  (space_w)
  );

  assign te_rise = throw_enable & ~te_q;
  assign te_fall = ~throw_enable & te_q;
  assign rs_rise = space_w & ~rs_q;
  assign rs_fall = ~space_w & rs_q;

  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    if (game_over) begin
      state_d = ST_OVER;
    end else if (game_start) begin
      state_d = start_first ? ST_L_WAIT : ST_R_WAIT;
      turn_d  = '0;
    end else begin
      case (state_q)
        ST_L_WAIT:   if (te_rise) state_d = ST_L_FLIGHT;
        ST_L_FLIGHT: if (te_fall) state_d = ST_GAP_TO_R;
        ST_GAP_TO_R: if (cnt_q == GAP_LAST) begin
          state_d = ST_R_WAIT;
          turn_d  = turn_q + 8'd1;
        end
        ST_R_WAIT:   if (rs_rise) state_d = ST_R_PRESS;
        ST_R_PRESS:  if (rs_fall) state_d = ST_R_FLIGHT;
        ST_R_FLIGHT: if (cnt_q == FLIGHT_LAST) state_d = ST_GAP_TO_L;
        ST_GAP_TO_L: if (cnt_q == GAP_LAST) begin
          state_d = ST_L_WAIT;
          turn_d  = turn_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Any state entry (including a restart into the same state) restarts the shared counter.
  always_comb begin
    timed = (state_d == state_q) && !game_over && !game_start &&
            ((state_q == ST_GAP_TO_R) || (state_q == ST_R_FLIGHT) || (state_q == ST_GAP_TO_L));
    cnt_d = timed ? cnt_q + 32'd1 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      turn_q  <= '0;
      te_q    <= 1'b0;
      rs_q    <= 1'b0;
      whose_q <= 1'b1;
      rte_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      turn_q  <= turn_d;
      te_q    <= throw_enable;
      rs_q    <= space_w;
      whose_q <= ~turn_is_local(state_d);
      rte_q   <= (state_d == ST_R_FLIGHT);
    end
  end

  assign whose_turn          = whose_q;
  assign remote_throw_enable = rte_q;
  assign remote_space        = space_w;
  assign turn_num            = turn_q;

endmodule

// File: tb/tb_turn_ctrl.sv
// Randomized and directed bench for turn_ctrl against a phase/countdown reference model.
module tb_turn_ctrl;

  localparam int FLIGHT = 20;
  localparam int GAP    = 4;
  localparam int SS     = 3;

  localparam int P_IDLE = 0, P_LW = 1, P_LF = 2, P_GR = 3, P_RW = 4,
                 P_RP = 5, P_RF = 6, P_GL = 7, P_OVER = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_start = 1'b0;
  logic       game_over = 1'b0;
  logic       start_first = 1'b0;
  logic       throw_enable = 1'b0;
  logic       space_pin_rx = 1'b0;
  logic       whose_turn;
  logic       remote_throw_enable;
  logic       remote_space;
  logic [7:0] turn_num;

  int tests = 0;
  int fails = 0;

  turn_ctrl #(.FLIGHT_CYCLES(FLIGHT), .GAP_CYCLES(GAP), .SYNC_STABLE(SS)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .game_start          (game_start),
    .game_over           (game_over),
    .start_first         (start_first),
    .throw_enable        (throw_enable),
    .space_pin_rx        (space_pin_rx),
    .whose_turn          (whose_turn),
    .remote_throw_enable (remote_throw_enable),
    .remote_space        (remote_space),
    .turn_num            (turn_num)
  );

  always #5 clk = ~clk;

  // Reference model: named phase plus a countdown of cycles left in timed phases.
  int m_ph = P_IDLE, m_left = 0, m_turns = 0, m_incs = 0, m_run = 0;
  bit m_sync1 = 0, m_sync2 = 0, m_space = 0, m_space_prev = 0, m_te_prev = 0;

  task automatic model_step();
    bit te_r, te_f, rs_r, rs_f;
    if (!rst_n) begin
      m_ph = P_IDLE; m_left = 0; m_turns = 0; m_run = 0;
      m_sync1 = 0; m_sync2 = 0; m_space = 0; m_space_prev = 0; m_te_prev = 0;
      return;
    end
    te_r = throw_enable && !m_te_prev;
    te_f = !throw_enable && m_te_prev;
    rs_r = m_space && !m_space_prev;
    rs_f = !m_space && m_space_prev;
    if (game_over) begin
      m_ph = P_OVER;
    end else if (game_start) begin
      m_ph = start_first ? P_LW : P_RW;
      m_turns = 0;
    end else begin
      case (m_ph)
        P_LW: if (te_r) m_ph = P_LF;
        P_LF: if (te_f) begin m_ph = P_GR; m_left = GAP; end
        P_GR: if (m_left == 1) begin m_ph = P_RW; m_turns = (m_turns + 1) % 256; m_incs++; end
              else m_left--;
        P_RW: if (rs_r) m_ph = P_RP;
        P_RP: if (rs_f) begin m_ph = P_RF; m_left = FLIGHT; end
        P_RF: if (m_left == 1) begin m_ph = P_GL; m_left = GAP; end
              else m_left--;
        P_GL: if (m_left == 1) begin m_ph = P_LW; m_turns = (m_turns + 1) % 256; m_incs++; end
              else m_left--;
        default: ;
      endcase
    end
    m_space_prev = m_space;
    if (m_sync2 != m_space) begin
      m_run++;
      if (m_run == SS) begin m_space = m_sync2; m_run = 0; end
    end else begin
      m_run = 0;
    end
    m_sync2 = m_sync1;
    m_sync1 = space_pin_rx;
    m_te_prev = throw_enable;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40)
        $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("whose_turn", int'(whose_turn), (m_ph == P_LW || m_ph == P_LF) ? 0 : 1);
    chk("remote_throw_enable", int'(remote_throw_enable), (m_ph == P_RF) ? 1 : 0);
    chk("remote_space", int'(remote_space), int'(m_space));
    chk("turn_num", int'(turn_num), m_turns);
  end

  task automatic pulse_start(input logic first);
    @(negedge clk); start_first = first; game_start = 1'b1;
    @(negedge clk); game_start = 1'b0;
  endtask

  initial begin : watchdog
    #900_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin : main
    int cnt;
    int base;
    int cyc;
    bit glitch_seen;

    repeat (3) @(negedge clk);
    chk("reset_whose", int'(whose_turn), 1);
    chk("reset_rte", int'(remote_throw_enable), 0);
    chk("reset_turn", int'(turn_num), 0);
    rst_n = 1'b1;

    pulse_start(1'b1);
    $display("[TB] start local-first: whose_turn=%0d turn_num=%0d", whose_turn, turn_num);
    chk("start_whose", int'(whose_turn), 0);
    chk("start_turn", int'(turn_num), 0);

    throw_enable = 1'b1;
    repeat (10) @(negedge clk);
    throw_enable = 1'b0;
    @(negedge clk);
    chk("fall_whose", int'(whose_turn), 1);
    repeat (3) @(negedge clk);
    chk("gap_end_whose", int'(whose_turn), 1);
    chk("gap_end_turn", int'(turn_num), 0);
    @(negedge clk);
    chk("rwait_turn", int'(turn_num), 1);
    $display("[TB] local turn done: turn_num=%0d", turn_num);

    space_pin_rx = 1'b1;
    repeat (8) @(negedge clk);
    space_pin_rx = 1'b0;
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (remote_throw_enable) cnt++;
    end
    chk("remote_flight_len", cnt, 20);
    chk("remote_done_whose", int'(whose_turn), 0);
    chk("remote_done_turn", int'(turn_num), 2);
    $display("[TB] remote turn done: flight=%0d turn_num=%0d", cnt, turn_num);

    throw_enable = 1'b1;
    repeat (3) @(negedge clk);
    throw_enable = 1'b0;
    repeat (6) @(negedge clk);
    chk("second_local_turn", int'(turn_num), 3);
    space_pin_rx = 1'b1;
    repeat (2) @(negedge clk);
    space_pin_rx = 1'b0;
    glitch_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (remote_space) glitch_seen = 1;
    end
    chk("glitch_rejected", int'(glitch_seen), 0);
    chk("glitch_whose", int'(whose_turn), 1);
    $display("[TB] glitch test: remote_space_seen=%0d", glitch_seen);

    space_pin_rx = 1'b1;
    repeat (8) @(negedge clk);
    space_pin_rx = 1'b0;
    cnt = 0;
    while (!remote_throw_enable && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("reach_flight_in_budget", int'(remote_throw_enable), 1);
    repeat (5) @(negedge clk);
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    chk("over_rte", int'(remote_throw_enable), 0);
    chk("over_whose", int'(whose_turn), 1);
    repeat (10) @(negedge clk);
    chk("over_hold_whose", int'(whose_turn), 1);
    $display("[TB] game_over in flight: rte=%0d whose_turn=%0d", remote_throw_enable, whose_turn);

    pulse_start(1'($urandom_range(0, 1)));
    base = m_incs;
    cyc = 0;
    while ((m_incs - base) < 256 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      case (m_ph)
        P_LW:    throw_enable = 1'($urandom_range(0, 1));
        P_LF:    throw_enable = ($urandom_range(0, 2) != 0);
        default: throw_enable = ($urandom_range(0, 7) == 0);
      endcase
      case (m_ph)
        P_RW:    space_pin_rx = 1'((cyc / 8) % 2);
        P_RP:    space_pin_rx = ($urandom_range(0, 5) == 0);
        default: space_pin_rx = ($urandom_range(0, 9) == 0);
      endcase
    end
    throw_enable = 1'b0;
    space_pin_rx = 1'b0;
    chk("wrap_within_budget", int'(cyc < 40000), 1);
    chk("wrap_turn", int'(turn_num), 0);
    $display("[TB] 256 turns in %0d cycles: turn_num=%0d", cyc, turn_num);

    @(negedge clk);
    game_start = 1'b1; game_over = 1'b1; start_first = 1'b1;
    @(negedge clk);
    game_start = 1'b0; game_over = 1'b0;
    chk("prio_whose", int'(whose_turn), 1);
    repeat (5) @(negedge clk);
    chk("prio_hold_whose", int'(whose_turn), 1);
    chk("prio_rte", int'(remote_throw_enable), 0);

    pulse_start(1'b0);
    repeat (3) @(negedge clk);
    chk("restart_remote_whose", int'(whose_turn), 1);
    pulse_start(1'b1);
    chk("restart_local_whose", int'(whose_turn), 0);
    chk("restart_turn", int'(turn_num), 0);

    throw_enable = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_whose", int'(whose_turn), 1);
    chk("async_reset_rte", int'(remote_throw_enable), 0);
    throw_enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_whose", int'(whose_turn), 1);
    $display("[TB] mid-flight reset: whose_turn=%0d", whose_turn);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
